// File: rtl/cdc_data_handshake_if.sv
// Bus for cdc_data_handshake: domain-A word offer/accept signals and domain-B delivery signals.
// master = the producer/consumer side, slave = the crossing itself.
interface cdc_data_handshake_if #(
   parameter int P_DATA_WIDTH = 32,
   parameter int P_CNT_WIDTH  = 16
);
   logic                    i_valid_a;
   logic [P_DATA_WIDTH-1:0] i_data_a;
   logic                    o_ready_a;
   logic                    o_busy_a;
   logic [P_CNT_WIDTH-1:0]  o_drop_cnt_a;
   logic                    o_valid_b;
   logic [P_DATA_WIDTH-1:0] o_data_b;

   modport master (
      output i_valid_a,
      output i_data_a,
      input  o_ready_a,
      input  o_busy_a,
      input  o_drop_cnt_a,
      input  o_valid_b,
      input  o_data_b
   );

   modport slave (
      input  i_valid_a,
      input  i_data_a,
      output o_ready_a,
      output o_busy_a,
      output o_drop_cnt_a,
      output o_valid_b,
      output o_data_b
   );
endinterface

// File: rtl/cdc_data_handshake.sv
// Carries one word from i_clk_a to i_clk_b over a 4-phase req/ack handshake; o_valid_b fires
// P_SYNC_STAGES+1 clk_b edges after req. Mode 0 stalls the source via o_ready_a, mode 1 drops and counts.
module cdc_data_handshake #(
   parameter int P_DATA_WIDTH  = 32,
   parameter int P_SYNC_STAGES = 2,
   parameter int P_MODE        = 0,
   parameter int P_CNT_WIDTH   = 16
) (
   input  logic                 i_clk_a,
   input  logic                 i_rst_a,
   input  logic                 i_clk_b,
   input  logic                 i_rst_b,
   cdc_data_handshake_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WAIT_ACK_H = 2'd1,
      S_WAIT_ACK_L = 2'd2
   } state_t;

   localparam logic MODE_PULSE = (P_MODE != 0);

   state_t                   state;
   logic                     r_req_a;
   logic [P_DATA_WIDTH-1:0]  hold_a;
   logic                     ready_q;
   logic                     busy_q;
   logic [P_CNT_WIDTH-1:0]   drop_cnt_q;
   logic [P_SYNC_STAGES-1:0] ack_sync_a;
   logic                     ack_a;

   logic [P_SYNC_STAGES-1:0] req_sync_b;
   logic                     req_b;
   logic                     req_d_b;
   logic                     req_rise_b;
   logic                     r_ack_b;
   logic                     valid_b_q;
   logic [P_DATA_WIDTH-1:0]  data_b_q;

   // ---------------- domain A ----------------
   assign ack_a = ack_sync_a[P_SYNC_STAGES-1];

   always_ff @(posedge i_clk_a or posedge i_rst_a) begin
      if (i_rst_a) begin
         ack_sync_a <= '0;
      end else begin
         ack_sync_a <= {ack_sync_a[P_SYNC_STAGES-2:0], r_ack_b};
      end
   end

   always_ff @(posedge i_clk_a or posedge i_rst_a) begin
      if (i_rst_a) begin
         state      <= S_IDLE;
         r_req_a    <= 1'b0;
         hold_a     <= '0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         drop_cnt_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.i_valid_a) begin
                  hold_a  <= bus.i_data_a;
                  r_req_a <= 1'b1;
                  busy_q  <= 1'b1;
                  ready_q <= MODE_PULSE;
                  state   <= S_WAIT_ACK_H;
               end
            end
            S_WAIT_ACK_H: begin
               if (ack_a) begin
                  r_req_a <= 1'b0;
                  state   <= S_WAIT_ACK_L;
               end
            end
            S_WAIT_ACK_L: begin
               // A word offered on this returning edge is not taken; it sees the FSM as busy.
               if (!ack_a) begin
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: begin
               r_req_a <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
         endcase

         if (MODE_PULSE && bus.i_valid_a && (state != S_IDLE) && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end
      end
   end

   assign bus.o_ready_a    = ready_q;
   assign bus.o_busy_a     = busy_q;
   assign bus.o_drop_cnt_a = drop_cnt_q;

   // ---------------- domain B ----------------
   // hold_a is sampled only on a req rising edge, when it has been stable for the whole sync delay.
   assign req_b      = req_sync_b[P_SYNC_STAGES-1];
   assign req_rise_b = req_b & ~req_d_b;

   always_ff @(posedge i_clk_b or posedge i_rst_b) begin
      if (i_rst_b) begin
         req_sync_b <= '0;
         req_d_b    <= 1'b0;
         r_ack_b    <= 1'b0;
         valid_b_q  <= 1'b0;
         data_b_q   <= '0;
      end else begin
         req_sync_b <= {req_sync_b[P_SYNC_STAGES-2:0], r_req_a};
         req_d_b    <= req_b;
         valid_b_q  <= req_rise_b;
         if (req_rise_b) begin
            data_b_q <= hold_a;
            r_ack_b  <= 1'b1;
         end else if (!req_b) begin
            r_ack_b  <= 1'b0;
         end
      end
   end

   assign bus.o_valid_b = valid_b_q;
   assign bus.o_data_b  = data_b_q;

endmodule

// File: tb/tb_cdc_data_handshake.sv
// Bench for cdc_data_handshake: three instances (mode 0 / sync 2, mode 1 / 4-bit counter, mode 0 / sync 4)
// share clocks and resets; a selector routes the stimulus and the delivery monitor to one of them at a time.
module tb_cdc_data_handshake;

   logic clk_a = 1'b0;
   logic clk_b = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   ha    = 50;
   int   hb    = 50;

   always #(ha) clk_a = ~clk_a;
   always #(hb) clk_b = ~clk_b;

   logic        tb_valid = 1'b0;
   logic [31:0] tb_data  = '0;
   logic [1:0]  sel      = 2'd0;

   cdc_data_handshake_if #(.P_DATA_WIDTH(32), .P_CNT_WIDTH(16)) bus0 ();
   cdc_data_handshake_if #(.P_DATA_WIDTH(32), .P_CNT_WIDTH(4))  bus1 ();
   cdc_data_handshake_if #(.P_DATA_WIDTH(32), .P_CNT_WIDTH(16)) bus2 ();

   cdc_data_handshake #(.P_DATA_WIDTH(32), .P_SYNC_STAGES(2), .P_MODE(0), .P_CNT_WIDTH(16)) u0 (
      .i_clk_a(clk_a), .i_rst_a(rst_a), .i_clk_b(clk_b), .i_rst_b(rst_b), .bus(bus0));
   cdc_data_handshake #(.P_DATA_WIDTH(32), .P_SYNC_STAGES(2), .P_MODE(1), .P_CNT_WIDTH(4)) u1 (
      .i_clk_a(clk_a), .i_rst_a(rst_a), .i_clk_b(clk_b), .i_rst_b(rst_b), .bus(bus1));
   cdc_data_handshake #(.P_DATA_WIDTH(32), .P_SYNC_STAGES(4), .P_MODE(0), .P_CNT_WIDTH(16)) u2 (
      .i_clk_a(clk_a), .i_rst_a(rst_a), .i_clk_b(clk_b), .i_rst_b(rst_b), .bus(bus2));

   assign bus0.i_valid_a = tb_valid && (sel == 2'd0);
   assign bus1.i_valid_a = tb_valid && (sel == 2'd1);
   assign bus2.i_valid_a = tb_valid && (sel == 2'd2);
   assign bus0.i_data_a  = tb_data;
   assign bus1.i_data_a  = tb_data;
   assign bus2.i_data_a  = tb_data;

   logic        m_ready, m_busy, m_valid_b;
   logic [15:0] m_drop;
   logic [31:0] m_data_b;
   assign m_ready   = (sel == 2'd1) ? bus1.o_ready_a : (sel == 2'd2) ? bus2.o_ready_a : bus0.o_ready_a;
   assign m_busy    = (sel == 2'd1) ? bus1.o_busy_a  : (sel == 2'd2) ? bus2.o_busy_a  : bus0.o_busy_a;
   assign m_valid_b = (sel == 2'd1) ? bus1.o_valid_b : (sel == 2'd2) ? bus2.o_valid_b : bus0.o_valid_b;
   assign m_data_b  = (sel == 2'd1) ? bus1.o_data_b  : (sel == 2'd2) ? bus2.o_data_b  : bus0.o_data_b;
   assign m_drop    = (sel == 2'd1) ? {12'd0, bus1.o_drop_cnt_a} :
                      (sel == 2'd2) ? bus2.o_drop_cnt_a : bus0.o_drop_cnt_a;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] rx_q[$];
   logic [31:0] exp_q[$];
   logic        prev_vb = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Delivery monitor: collects every word and insists each pulse is a single clk_b cycle.
   always @(posedge clk_b) begin
      #1;
      if (m_valid_b) begin
         check("pulse_width", {63'd0, prev_vb}, 64'd0);
         rx_q.push_back(m_data_b);
      end
      prev_vb = m_valid_b;
   end

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      @(negedge clk_a);
      while (m_busy && g < 2000) begin
         @(negedge clk_a);
         g++;
      end
      check({tag, "_idle"}, {63'd0, m_busy}, 64'd0);
      repeat (4) @(posedge clk_b);
      #2;
   endtask

   task automatic cmp_queues(input string tag);
      check({tag, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check({tag, "_word"}, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic pulse_reset();
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(negedge clk_a);
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (2) @(negedge clk_a);
   endtask

   // Back-pressure source: every word offered stays offered until the bench sees ready ahead of an edge.
   task automatic drive_m0(input int n, input bit rnd);
      int          k;
      int          g;
      bit          ok;
      logic [31:0] w;
      k  = 0;
      ok = 1'b1;
      while (k < n && ok) begin
         w = rnd ? $urandom : 32'(k);
         @(negedge clk_a);
         tb_data  = w;
         tb_valid = 1'b1;
         g = 0;
         while (!m_ready && g < 2000) begin
            @(negedge clk_a);
            g++;
         end
         if (!m_ready) begin
            ok = 1'b0;
         end else begin
            @(posedge clk_a);
            #1;
            tb_valid = 1'b0;
            exp_q.push_back(w);
            k++;
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk_a);
         end
      end
      tb_valid = 1'b0;
      check("drive_accepts", k, n);
   endtask

   initial begin
      int          n, n_before, n_rel, n_del, exp_d, exp_drop, n_ready_low;
      logic        got;
      logic [31:0] w, prev_w;

      // Reset values, with a word offered throughout reset that must be ignored.
      tb_valid = 1'b1;
      tb_data  = 32'h1234_5678;
      repeat (4) @(negedge clk_a);
      check("rst_ready0", {63'd0, bus0.o_ready_a}, 64'd1);
      check("rst_ready1", {63'd0, bus1.o_ready_a}, 64'd1);
      check("rst_busy0", {63'd0, bus0.o_busy_a}, 64'd0);
      check("rst_drop1", {60'd0, bus1.o_drop_cnt_a}, 64'd0);
      check("rst_valid_b0", {63'd0, bus0.o_valid_b}, 64'd0);
      check("rst_data_b0", bus0.o_data_b, 64'd0);
      check("rst_data_b2", bus2.o_data_b, 64'd0);
      tb_valid = 1'b0;
      rst_a    = 1'b0;
      rst_b    = 1'b0;
      repeat (10) @(negedge clk_a);
      check("rst_no_busy", {63'd0, bus0.o_busy_a}, 64'd0);
      check("rst_no_rx", rx_q.size(), 0);

      // Single word, equal clocks: latency and ready behaviour.
      sel = 2'd0;
      @(negedge clk_a);
      tb_data  = 32'hDEAD_BEEF;
      tb_valid = 1'b1;
      @(posedge clk_a);
      #1;
      tb_valid = 1'b0;
      check("t1_ready_low", {63'd0, m_ready}, 64'd0);
      check("t1_busy", {63'd0, m_busy}, 64'd1);
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk_b);
         n++;
         #1;
         got = m_valid_b;
      end
      check("t1_latency", n, 3);
      check("t1_data", m_data_b, 32'hDEAD_BEEF);
      @(posedge clk_b);
      #1;
      check("t1_pulse_end", {63'd0, m_valid_b}, 64'd0);
      wait_idle("t1");
      check("t1_ready_high", {63'd0, m_ready}, 64'd1);
      exp_q.push_back(32'hDEAD_BEEF);
      cmp_queues("t1");

      // Fast source, slow destination, valid held: 0..99 in order.
      ha = 20;
      hb = 200;
      repeat (2) @(negedge clk_b);
      drive_m0(100, 1'b0);
      wait_idle("t2");
      exp_q.delete();
      for (int i = 0; i < 100; i++) exp_q.push_back(32'(i));
      cmp_queues("t2");
      check("t2_drop", m_drop, 0);

      // Destination reset while the source waits for ack: before and after the first delivery.
      ha = 50;
      hb = 50;
      repeat (2) @(negedge clk_a);
      for (int sc = 0; sc < 2; sc++) begin
         w = $urandom;
         @(negedge clk_a);
         tb_data  = w;
         tb_valid = 1'b1;
         @(posedge clk_a);
         #1;
         tb_valid = 1'b0;
         if (sc == 1) begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 20) begin
               @(posedge clk_b);
               n++;
               #1;
               got = m_valid_b;
            end
            check("t5_first_delivery", {63'd0, got}, 64'd1);
         end
         check("t5_in_wait", {63'd0, m_busy}, 64'd1);
         #2;
         n_before = rx_q.size();
         rst_b = 1'b1;
         repeat (3) @(posedge clk_b);
         #1;
         rst_b = 1'b0;
         n_rel = rx_q.size();
         check("t5_none_in_reset", n_rel, n_before);
         wait_idle("t5");
         check("t5_at_most_once", {63'd0, (rx_q.size() - n_rel) <= 1}, 64'd1);
         check("t5_total", {63'd0, rx_q.size() >= 1 && rx_q.size() <= 1 + sc}, 64'd1);
         foreach (rx_q[i]) check("t5_word", rx_q[i], w);
         rx_q.delete();
         drive_m0(1, 1'b1);
         wait_idle("t5_next");
         cmp_queues("t5_next");
      end

      // Pulse mode, one word offered every cycle for 200 cycles.
      sel         = 2'd1;
      n_ready_low = 0;
      repeat (2) @(negedge clk_a);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_a);
         if (!m_ready) n_ready_low++;
         if (i == 5) check("t3_drop_early", m_drop, 4);
         tb_valid = 1'b1;
         tb_data  = 32'(i);
      end
      @(negedge clk_a);
      tb_valid = 1'b0;
      wait_idle("t3");
      n_del = rx_q.size();
      check("t3_ready_always", n_ready_low, 0);
      check("t3_delivered_range", {63'd0, n_del >= 10 && n_del <= 25}, 64'd1);
      if (n_del > 0) check("t3_first_word", rx_q[0], 32'd0);
      prev_w = '0;
      for (int j = 0; j < n_del; j++) begin
         check("t3_subset_order", {63'd0, (rx_q[j] < 200) && (j == 0 || rx_q[j] > prev_w)}, 64'd1);
         prev_w = rx_q[j];
      end
      exp_d = 200 - n_del;
      if (exp_d > 15) exp_d = 15;
      check("t3_drop_sat", m_drop, exp_d);
      rx_q.delete();

      // Offer on the edge where the FSM returns to idle, then on the edge after.
      pulse_reset();
      rx_q.delete();
      @(negedge clk_a);
      tb_data  = 32'hA5A5_0000;
      tb_valid = 1'b1;
      @(negedge clk_a);
      check("t4_busy", {63'd0, m_busy}, 64'd1);
      exp_drop = 0;
      n        = 0;
      while (m_busy && n < 100) begin
         tb_data = 32'hC000_0000 + 32'(n);
         exp_drop++;
         n++;
         @(negedge clk_a);
      end
      if (exp_drop > 15) exp_drop = 15;
      check("t4_drop_collision", m_drop, exp_drop);
      tb_data = 32'hD00D_F00D;
      @(negedge clk_a);
      check("t4_accept_after", {63'd0, m_busy}, 64'd1);
      check("t4_drop_hold", m_drop, exp_drop);
      tb_valid = 1'b0;
      wait_idle("t4");
      exp_q.push_back(32'hA5A5_0000);
      exp_q.push_back(32'hD00D_F00D);
      cmp_queues("t4");

      // Deep synchronisers, slow source, fast destination, random words.
      sel = 2'd2;
      ha  = 150;
      hb  = 25;
      repeat (2) @(negedge clk_a);
      drive_m0(1000, 1'b1);
      wait_idle("t6");
      cmp_queues("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
